// File: rtl/axis_packet_scheduler.sv
// axis_packet_scheduler: packet-granular round-robin grant of one shared AXI-stream path with quota and stall watchdog
module axis_packet_scheduler #(
  parameter int NUM     = 8,
  parameter int QW      = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM-1:0]          req,
  input  logic [QW-1:0]           quantum,
  input  logic                    xfer,
  input  logic                    xlast,
  output logic [NUM-1:0]          grant,
  output logic [$clog2(NUM)-1:0]  grant_id,
  output logic                    grant_vld,
  output logic                    timeout
);
  localparam int IW = $clog2(NUM);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state_q;
  logic [NUM-1:0] grant_q;
  logic [IW-1:0]  grant_id_q, last_id_q, win;
  logic [QW-1:0]  pkt_left_q;
  logic           in_pkt_q, timeout_q;
  logic [WW-1:0]  wd_q, wd_d;
  logic           fin, drain, expire;
  // first requester found searching upward from the slot after the previous winner
  always_comb begin
    int   j;
    logic [IW-1:0] idx;
    win = last_id_q;
    j   = 0;
    idx = '0;
    for (int k = NUM; k >= 1; k--) begin
      j = int'(last_id_q) + k;
      if (j >= NUM) j = j - NUM;
      idx = IW'(j);
      if (req[idx]) win = idx;
    end
  end
  // release conditions: quota exhausted, drained at a boundary, or watchdog expiry
  always_comb begin
    wd_d   = xfer ? '0 : (wd_q == WW'(TIMEOUT) ? wd_q : wd_q + 1'b1);
    expire = (TIMEOUT != 0) && !xfer && (wd_d == WW'(TIMEOUT));
    fin    = xfer && xlast && (pkt_left_q == QW'(1));
    drain  = !in_pkt_q && !xfer && !req[grant_id_q];
  end
  // grant FSM with registered outputs; forced release still leaves last_id at the stalled source
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= IW'(NUM - 1);
      pkt_left_q <= '0;
      in_pkt_q   <= 1'b0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|req) begin
          state_q    <= GRANT;
          grant_q    <= NUM'(1) << win;
          grant_id_q <= win;
          last_id_q  <= win;
          pkt_left_q <= quantum == '0 ? QW'(1) : quantum;
          in_pkt_q   <= 1'b0;
          wd_q       <= '0;
        end
      end else begin
        wd_q <= wd_d;
        if (xfer) in_pkt_q <= !xlast;
        if (xfer && xlast) pkt_left_q <= pkt_left_q - 1'b1;
        if (fin || drain || expire) begin
          state_q  <= IDLE;
          grant_q  <= '0;
          in_pkt_q <= 1'b0;
        end
        if (expire) timeout_q <= 1'b1;
      end
    end
  end
  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign grant_vld = |grant_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_axis_packet_scheduler.sv
// tb_axis_packet_scheduler: directed and random checks of the scheduler against a packet-level reference model
module tb_axis_packet_scheduler;
  localparam int NUM = 8;
  localparam int QW  = 4;
  localparam int TO  = 16;
  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [NUM-1:0] req = '0;
  logic [QW-1:0]  quantum = 4'd1;
  logic           xfer = 1'b0;
  logic           xlast = 1'b0;
  logic [NUM-1:0] grant;
  logic [2:0]     grant_id;
  logic           grant_vld;
  logic           timeout;
  int n_chk = 0;
  int n_err = 0;
  int m_own = -1;
  int m_last = NUM - 1;
  int m_gid = 0;
  int m_left = 0;
  int m_idle = 0;
  bit m_in = 1'b0;
  bit m_to = 1'b0;

  axis_packet_scheduler #(.NUM(NUM), .QW(QW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .quantum(quantum), .xfer(xfer), .xlast(xlast),
    .grant(grant), .grant_id(grant_id), .grant_vld(grant_vld), .timeout(timeout)
  );

  // free-running clock
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int search(input logic [NUM-1:0] r);
    for (int k = 1; k <= NUM; k++)
      if (r[(m_last + k) % NUM]) return (m_last + k) % NUM;
    return -1;
  endfunction

  task automatic m_reset();
    m_own = -1; m_last = NUM - 1; m_gid = 0; m_left = 0; m_idle = 0; m_in = 0; m_to = 0;
  endtask

  task automatic m_step();
    bit rel;
    int w;
    rel = 0;
    if (!aresetn) begin
      m_reset();
      return;
    end
    m_to = 0;
    if (m_own < 0) begin
      w = search(req);
      if (w >= 0) begin
        m_own = w; m_last = w; m_gid = w;
        m_left = (quantum == 0) ? 1 : int'(quantum);
        m_in = 0; m_idle = 0;
      end
    end else begin
      if (xfer) begin
        m_idle = 0;
        if (xlast) begin
          m_in = 0;
          m_left--;
          if (m_left == 0) rel = 1;
        end else m_in = 1;
      end else begin
        m_idle++;
        if (!m_in && !req[m_own]) rel = 1;
        if (m_idle >= TO) begin
          rel = 1; m_to = 1; m_in = 0;
        end
      end
      if (rel) m_own = -1;
    end
  endtask

  task automatic check_out();
    logic [NUM-1:0] eg;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    chk("grant", grant, eg);
    chk("grant_id", grant_id, m_gid);
    chk("grant_vld", grant_vld, m_own >= 0);
    chk("timeout", timeout, m_to);
  endtask

  task automatic cyc();
    @(posedge aclk);
    m_step();
    #1;
    check_out();
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!grant_vld && n < 20) begin
      cyc();
      n++;
    end
    chk("grant_wait", grant_vld, 1);
  endtask

  task automatic pkt(input int len);
    for (int i = 0; i < len; i++) begin
      xfer = 1'b1;
      xlast = (i == len - 1);
      cyc();
    end
    xfer = 1'b0;
    xlast = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; req = '0; xfer = 1'b0; xlast = 1'b0;
    #1;
    m_reset();
    check_out();
    cyc();
    cyc();
    aresetn = 1'b1;
  endtask

  // directed scenarios followed by randomized traffic
  initial begin
    int n;
    int mode;
    #2;
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_id", grant_id, 0);
    for (int i = 0; i < 20; i++) cyc();
    chk("idle_grant", grant, 0);
    req = 8'hFF; quantum = 4'd1;
    for (int g = 0; g < 9; g++) begin
      wait_grant();
      chk("rr_order", grant_id, g % NUM);
      pkt(3);
      chk("rr_gap", grant_vld, 0);
    end
    do_reset();
    req = 8'h05; quantum = 4'd3;
    wait_grant();
    chk("q3_first", grant, 8'h01);
    for (int p = 0; p < 3; p++) begin
      pkt(2);
      chk("q3_hold", grant, p < 2 ? 8'h01 : 8'h00);
    end
    cyc();
    chk("q3_next", grant, 8'h04);
    req = 8'h00;
    cyc();
    chk("drain_drop", grant, 0);
    req = 8'h04; quantum = 4'd4;
    wait_grant();
    chk("s2_grant", grant, 8'h04);
    pkt(2);
    req = 8'h00;
    chk("s2_boundary", grant, 8'h04);
    cyc();
    chk("s2_release", grant, 0);
    do_reset();
    req = 8'h0A; quantum = 4'd2;
    wait_grant();
    chk("wd_owner", grant_id, 1);
    xfer = 1'b1;
    cyc();
    cyc();
    xfer = 1'b0;
    n = 1;
    while (!timeout && n < 40) begin
      cyc();
      n++;
    end
    chk("wd_delay", n, 17);
    chk("wd_drop", grant_vld, 0);
    cyc();
    chk("wd_next", grant_id, 3);
    do_reset();
    req = 8'h08;
    wait_grant();
    chk("mid_grant", grant, 8'h08);
    xfer = 1'b1;
    cyc();
    xfer = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst", grant, 0);
    m_reset();
    cyc();
    cyc();
    aresetn = 1'b1;
    req = 8'hFF;
    wait_grant();
    chk("restart_id", grant_id, 0);
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) req = NUM'($urandom);
      quantum = QW'($urandom_range(0, 15));
      xfer = $urandom_range(0, 99) < (mode == 0 ? 70 : mode == 1 ? 30 : 3);
      xlast = $urandom_range(0, 2) == 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
